// File: rtl/mvu_pe_acc_tree.sv
// rtl/mvu_pe_acc_tree.sv - pipelined SIMD adder tree with synapse-fold accumulation
module mvu_pe_acc_tree #(
   parameter int SIMD   = 2,
   parameter int TDstI  = 4,
   parameter int TAcc   = 16,
   parameter int SF     = 3,
   parameter int SIGNED = 0
) (
   input  logic             clock,
   input  logic             resetn,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [TDstI-1:0] in_simd [0:SIMD-1],
   output logic             out_valid,
   input  logic             out_ready,
   output logic [TAcc-1:0]  out_acc
);

   // Tree depth: one register level per halving, at least one level.
   localparam int L  = (SIMD > 2) ? $clog2(SIMD) : 1;
   localparam int CW = (SF > 1) ? $clog2(SF) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(SF - 1);

   // Number of live elements at a given tree level.
   function automatic int level_count(input int lvl);
      int n;
      n = SIMD;
      for (int j = 0; j < lvl; j++) n = (n + 1) / 2;
      return n;
   endfunction

   logic [TAcc-1:0] lane_ext   [0:SIMD-1];
   logic [TAcc-1:0] tree_data  [0:L][0:SIMD-1];
   logic            tree_valid [0:L];
   logic [CW-1:0]   cnt;
   logic [TAcc-1:0] acc;
   logic [TAcc-1:0] tree_sum;
   logic [TAcc-1:0] fold_sum;
   logic            adv;
   logic            last_beat;

   // A single advance enable freezes every stage while a result waits downstream.
   assign adv       = !out_valid || out_ready;
   assign in_ready  = adv;
   assign tree_sum  = tree_data[L][0];
   assign fold_sum  = (cnt == '0) ? tree_sum : acc + tree_sum;
   assign last_beat = tree_valid[L] && (cnt == CNT_LAST);

   // Widen each lane to the accumulator width, sign- or zero-extending.
   always_comb begin
      for (int i = 0; i < SIMD; i++) begin
         lane_ext[i] = '0;
         if (SIGNED != 0) lane_ext[i] = TAcc'($signed(in_simd[i]));
         else             lane_ext[i] = TAcc'(in_simd[i]);
      end
   end

   // Input capture plus the registered pairwise-add levels; odd leftovers pass through.
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         for (int l = 0; l <= L; l++) begin
            tree_valid[l] <= 1'b0;
            for (int i = 0; i < SIMD; i++) tree_data[l][i] <= '0;
         end
      end else if (adv) begin
         tree_valid[0] <= in_valid;
         if (in_valid) begin
            for (int i = 0; i < SIMD; i++) tree_data[0][i] <= lane_ext[i];
         end
         for (int l = 1; l <= L; l++) begin
            tree_valid[l] <= tree_valid[l-1];
            for (int i = 0; i < (SIMD + 1) / 2; i++) begin
               if (2*i + 1 < level_count(l-1))
                  tree_data[l][i] <= tree_data[l-1][2*i] + tree_data[l-1][(2*i + 1) % SIMD];
               else if (2*i < level_count(l-1))
                  tree_data[l][i] <= tree_data[l-1][2*i];
            end
         end
      end
   end

   // Fold accumulator: sums SF tree outputs, then presents the neuron result.
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         cnt       <= '0;
         acc       <= '0;
         out_acc   <= '0;
         out_valid <= 1'b0;
      end else if (adv) begin
         if (tree_valid[L]) begin
            acc <= fold_sum;
            if (cnt == CNT_LAST) begin
               out_acc <= fold_sum;
               cnt     <= '0;
            end else begin
               cnt <= cnt + CW'(1);
            end
         end
         out_valid <= last_beat;
      end
   end

endmodule

// File: tb/tb_mvu_pe_acc_tree.sv
// tb/tb_mvu_pe_acc_tree.sv - scoreboard bench for mvu_pe_acc_tree
module tb_mvu_pe_acc_tree;

   logic clock;
   logic resetn;

   logic        iv0, ir0, ov0, or0;
   logic [3:0]  s0 [0:3];
   logic [15:0] acc0;
   logic        iv1, ir1, ov1, or1;
   logic [3:0]  s1 [0:3];
   logic [15:0] acc1;
   logic        iv2, ir2, ov2, or2;
   logic [3:0]  s2 [0:3];
   logic [7:0]  acc2;
   logic        iv3, ir3, ov3, or3;
   logic [3:0]  s3 [0:4];
   logic [15:0] acc3;

   logic [15:0] q0 [$];
   logic [15:0] q1 [$];
   logic [7:0]  q2 [$];
   logic [15:0] q3 [$];

   int m0_sum, m0_cnt, m1_sum, m1_cnt, m2_sum, m2_cnt;
   int n_checks;
   int n_errors;
   int n;
   logic done0;

   mvu_pe_acc_tree #(.SIMD(4), .TDstI(4), .TAcc(16), .SF(3), .SIGNED(0)) u0 (
      .clock(clock), .resetn(resetn), .in_valid(iv0), .in_ready(ir0), .in_simd(s0),
      .out_valid(ov0), .out_ready(or0), .out_acc(acc0));
   mvu_pe_acc_tree #(.SIMD(4), .TDstI(4), .TAcc(16), .SF(3), .SIGNED(1)) u1 (
      .clock(clock), .resetn(resetn), .in_valid(iv1), .in_ready(ir1), .in_simd(s1),
      .out_valid(ov1), .out_ready(or1), .out_acc(acc1));
   mvu_pe_acc_tree #(.SIMD(4), .TDstI(4), .TAcc(8), .SF(5), .SIGNED(0)) u2 (
      .clock(clock), .resetn(resetn), .in_valid(iv2), .in_ready(ir2), .in_simd(s2),
      .out_valid(ov2), .out_ready(or2), .out_acc(acc2));
   mvu_pe_acc_tree #(.SIMD(5), .TDstI(4), .TAcc(16), .SF(1), .SIGNED(0)) u3 (
      .clock(clock), .resetn(resetn), .in_valid(iv3), .in_ready(ir3), .in_simd(s3),
      .out_valid(ov3), .out_ready(or3), .out_acc(acc3));

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic send0(input logic [3:0] a, input logic [3:0] b, input logic [3:0] c, input logic [3:0] d);
      int w;
      iv0 = 1'b1; s0[0] = a; s0[1] = b; s0[2] = c; s0[3] = d;
      m0_sum += int'(a) + int'(b) + int'(c) + int'(d);
      m0_cnt++;
      if (m0_cnt == 3) begin q0.push_back(16'(m0_sum)); m0_sum = 0; m0_cnt = 0; end
      w = 0;
      while (!ir0 && w < 200) begin tick(); w++; end
      if (w >= 200) check("u0_in_ready_timeout", 32'(ir0), 1);
      tick();
      iv0 = 1'b0;
   endtask

   task automatic send1(input logic [3:0] a, input logic [3:0] b, input logic [3:0] c, input logic [3:0] d);
      iv1 = 1'b1; s1[0] = a; s1[1] = b; s1[2] = c; s1[3] = d;
      m1_sum += int'($signed(a)) + int'($signed(b)) + int'($signed(c)) + int'($signed(d));
      m1_cnt++;
      if (m1_cnt == 3) begin q1.push_back(16'(m1_sum)); m1_sum = 0; m1_cnt = 0; end
      check("u1_in_ready", 32'(ir1), 1);
      tick();
      iv1 = 1'b0;
   endtask

   task automatic send2(input logic [3:0] a, input logic [3:0] b, input logic [3:0] c, input logic [3:0] d);
      iv2 = 1'b1; s2[0] = a; s2[1] = b; s2[2] = c; s2[3] = d;
      m2_sum += int'(a) + int'(b) + int'(c) + int'(d);
      m2_cnt++;
      if (m2_cnt == 5) begin q2.push_back(8'(m2_sum)); m2_sum = 0; m2_cnt = 0; end
      check("u2_in_ready", 32'(ir2), 1);
      tick();
      iv2 = 1'b0;
   endtask

   // Scoreboard pops: a transfer is sampled mid-cycle, so it is seen exactly once.
   always @(negedge clock) begin
      if (resetn && ov0 && or0) begin
         check("u0_result_expected", 32'(q0.size() != 0), 1);
         if (q0.size() != 0) check("u0_out_acc", 32'(acc0), 32'(q0.pop_front()));
      end
      if (resetn && ov1 && or1) begin
         check("u1_result_expected", 32'(q1.size() != 0), 1);
         if (q1.size() != 0) check("u1_out_acc", 32'(acc1), 32'(q1.pop_front()));
      end
      if (resetn && ov2 && or2) begin
         check("u2_result_expected", 32'(q2.size() != 0), 1);
         if (q2.size() != 0) check("u2_out_acc", 32'(acc2), 32'(q2.pop_front()));
      end
      if (resetn && ov3 && or3) begin
         check("u3_result_expected", 32'(q3.size() != 0), 1);
         if (q3.size() != 0) check("u3_out_acc", 32'(acc3), 32'(q3.pop_front()));
      end
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not complete");
      $fatal(1);
   end

   initial begin
      n_checks = 0; n_errors = 0;
      m0_sum = 0; m0_cnt = 0; m1_sum = 0; m1_cnt = 0; m2_sum = 0; m2_cnt = 0;
      done0 = 1'b0;
      iv0 = 0; iv1 = 0; iv2 = 0; iv3 = 0;
      or0 = 1; or1 = 1; or2 = 1; or3 = 1;
      for (int i = 0; i < 4; i++) begin s0[i] = '0; s1[i] = '0; s2[i] = '0; end
      for (int i = 0; i < 5; i++) s3[i] = '0;
      resetn = 1'b0;
      repeat (2) @(posedge clock);
      #1;
      resetn = 1'b1;

      check("rst_out_valid", 32'(ov0), 0);
      check("rst_in_ready", 32'(ir0), 1);
      check("rst_out_acc", 32'(acc0), 0);
      check("rst_out_valid_u3", 32'(ov3), 0);

      // Unsigned fold of three beats and its latency.
      send0(4'd1, 4'd2, 4'd3, 4'd4);
      send0(4'd5, 4'd5, 4'd5, 4'd5);
      send0(4'd15, 4'd15, 4'd15, 4'd15);
      n = 0;
      while (!ov0 && n < 10) begin tick(); n++; end
      check("u0_latency", 32'(n), 3);
      tick();
      check("u0_valid_one_cycle", 32'(ov0), 0);

      // Signed lanes.
      repeat (3) send1(4'hF, 4'hE, 4'hD, 4'hC);
      repeat (3) send1(4'h7, 4'h1, 4'h8, 4'h3);
      repeat (8) tick();

      // Wrap-around with bubbles inside the fold.
      for (int b = 0; b < 5; b++) begin
         send2(4'd15, 4'd15, 4'd15, 4'd15);
         repeat (b % 3) tick();
      end
      repeat (5) send2(4'd15, 4'd0, 4'd15, 4'd0);
      repeat (10) tick();

      // Odd lane count, SF=1, back-to-back results.
      iv3 = 1'b1;
      s3[0] = 4'd1; s3[1] = 4'd2; s3[2] = 4'd3; s3[3] = 4'd4; s3[4] = 4'd5;
      q3.push_back(16'd1 + 16'd2 + 16'd3 + 16'd4 + 16'd5);
      tick();
      for (int i = 0; i < 5; i++) s3[i] = 4'd5;
      q3.push_back(16'd25);
      tick();
      iv3 = 1'b0;
      n = 1;
      while (!ov3 && n < 10) begin tick(); n++; end
      check("u3_latency", 32'(n), 4);
      tick();
      check("u3_back_to_back", 32'(ov3), 1);
      tick();
      check("u3_valid_drop", 32'(ov3), 0);

      // Backpressure: stall with the next folds pending.
      or0 = 1'b0;
      fork
         begin
            send0(4'd1, 4'd2, 4'd3, 4'd4);
            send0(4'd5, 4'd5, 4'd5, 4'd5);
            send0(4'd15, 4'd15, 4'd15, 4'd15);
            repeat (3) send0(4'd1, 4'd1, 4'd1, 4'd1);
            repeat (3) send0(4'd2, 4'd2, 4'd2, 4'd2);
            done0 = 1'b1;
         end
      join_none
      n = 0;
      while (!ov0 && n < 50) begin tick(); n++; end
      check("u0_bp_valid", 32'(ov0), 1);
      for (int j = 0; j < 4; j++) begin
         tick();
         check("u0_bp_in_ready", 32'(ir0), 0);
         check("u0_bp_stable", 32'(acc0), 90);
         check("u0_bp_held", 32'(ov0), 1);
      end
      or0 = 1'b1;
      n = 0;
      while (!done0 && n < 100) begin tick(); n++; end
      check("u0_bp_drained", 32'(done0), 1);
      repeat (8) tick();
      check("u0_bp_q_empty", 32'(q0.size()), 0);

      // Reset in the middle of a fold while a result is held.
      or0 = 1'b0;
      send0(4'd1, 4'd2, 4'd3, 4'd4);
      send0(4'd5, 4'd5, 4'd5, 4'd5);
      send0(4'd15, 4'd15, 4'd15, 4'd15);
      send0(4'd7, 4'd7, 4'd7, 4'd7);
      send0(4'd7, 4'd7, 4'd7, 4'd7);
      n = 0;
      while (!ov0 && n < 20) begin tick(); n++; end
      check("u0_pre_reset_valid", 32'(ov0), 1);
      check("u0_q_before_reset", 32'(q0.size()), 1);
      #2;
      resetn = 1'b0;
      #1;
      check("u0_reset_out_valid", 32'(ov0), 0);
      check("u0_reset_in_ready", 32'(ir0), 1);
      check("u0_reset_out_acc", 32'(acc0), 0);
      q0.delete();
      m0_sum = 0; m0_cnt = 0;
      #1;
      resetn = 1'b1;
      or0 = 1'b1;
      tick();
      repeat (3) send0(4'd1, 4'd1, 4'd1, 4'd1);
      repeat (8) tick();

      check("q0_empty", 32'(q0.size()), 0);
      check("q1_empty", 32'(q1.size()), 0);
      check("q2_empty", 32'(q2.size()), 0);
      check("q3_empty", 32'(q3.size()), 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
